// File: rtl/rbcp_master_if.sv
// Bundle of the local command/data channels and the RBCP bus driven by rbcp_master.
// The master modport is the initiator's view; slave is the view of whatever sits opposite.
`timescale 1ns/1ps
interface rbcp_master_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic        WD_VALID;
    logic        WD_READY;
    logic [7:0]  WD_DATA;
    logic        RD_VALID;
    logic [7:0]  RD_DATA;
    logic        DONE;
    logic        ERR;
    logic [7:0]  BYTE_CNT;
    logic        RBCP_ACT;
    logic [31:0] RBCP_ADDR;
    logic        RBCP_WE;
    logic [7:0]  RBCP_WD;
    logic        RBCP_RE;
    logic [7:0]  RBCP_RD;
    logic        RBCP_ACK;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA, RBCP_RD, RBCP_ACK,
        output CMD_READY, WD_READY, RD_VALID, RD_DATA, DONE, ERR, BYTE_CNT,
               RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_LEN, WD_VALID, WD_DATA, RBCP_RD, RBCP_ACK,
        input  CMD_READY, WD_READY, RD_VALID, RD_DATA, DONE, ERR, BYTE_CNT,
               RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE
    );
endinterface

// File: rtl/rbcp_master.sv
// RBCP initiator: turns a byte-burst command into single-byte RBCP strobes with an
// auto-incrementing address, ACK timeout and per-command DONE/ERR/BYTE_CNT status.
`timescale 1ns/1ps
module rbcp_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ACT_LEAD       = 1
) (
    input logic           CLK,
    input logic           RST,
    rbcp_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEAD, FETCH, STROBE, WAIT_ACK, FINISH} state_t;

    localparam logic [1:0]  LEAD_LAST = 2'(ACT_LEAD - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        cmd_ready_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [7:0]  len_q;
    logic [1:0]  lead_cnt_q;
    logic [15:0] to_cnt_q;
    logic        wd_ready_q;
    logic [7:0]  wd_q;
    logic        we_q;
    logic        re_q;
    logic        act_q;
    logic        rd_valid_q;
    logic [7:0]  rd_data_q;
    logic        done_q;
    logic        err_q;
    logic [7:0]  byte_cnt_q;

    logic [31:0] addr_d;
    logic [7:0]  len_d;
    logic [7:0]  byte_cnt_d;

    always_comb begin
        addr_d     = addr_q + 32'd1;
        len_d      = len_q - 8'd1;
        byte_cnt_d = byte_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            lead_cnt_q  <= '0;
            to_cnt_q    <= '0;
            wd_ready_q  <= 1'b0;
            wd_q        <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            act_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_ready_q && bus.CMD_VALID) begin
                        cmd_ready_q <= 1'b0;
                        write_q     <= bus.CMD_WRITE;
                        addr_q      <= bus.CMD_ADDR;
                        len_q       <= bus.CMD_LEN;
                        err_q       <= 1'b0;
                        byte_cnt_q  <= '0;
                        lead_cnt_q  <= '0;
                        if (bus.CMD_LEN == 8'd0) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            act_q   <= 1'b1;
                            state_q <= LEAD;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                LEAD: begin
                    if (lead_cnt_q == LEAD_LAST) begin
                        if (write_q) begin
                            wd_ready_q <= 1'b1;
                            state_q    <= FETCH;
                        end else begin
                            re_q    <= 1'b1;
                            state_q <= STROBE;
                        end
                    end else begin
                        lead_cnt_q <= lead_cnt_q + 2'd1;
                    end
                end
                // For reads this state is only the one-cycle gap between ACK and the next strobe.
                FETCH: begin
                    if (!write_q) begin
                        re_q    <= 1'b1;
                        state_q <= STROBE;
                    end else if (wd_ready_q && bus.WD_VALID) begin
                        wd_q       <= bus.WD_DATA;
                        wd_ready_q <= 1'b0;
                        we_q       <= 1'b1;
                        state_q    <= STROBE;
                    end
                end
                STROBE: begin
                    to_cnt_q <= 16'd1;
                    state_q  <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (bus.RBCP_ACK) begin
                        rd_valid_q <= !write_q;
                        rd_data_q  <= bus.RBCP_RD;
                        byte_cnt_q <= byte_cnt_d;
                        addr_q     <= addr_d;
                        len_q      <= len_d;
                        if (len_q == 8'd1) begin
                            act_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            wd_ready_q <= write_q;
                            state_q    <= FETCH;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        act_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        to_cnt_q <= to_cnt_q + 16'd1;
                    end
                end
                FINISH: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.WD_READY  = wd_ready_q;
    assign bus.RD_VALID  = rd_valid_q;
    assign bus.RD_DATA   = rd_data_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.BYTE_CNT  = byte_cnt_q;
    assign bus.RBCP_ACT  = act_q;
    assign bus.RBCP_ADDR = addr_q;
    assign bus.RBCP_WE   = we_q;
    assign bus.RBCP_WD   = wd_q;
    assign bus.RBCP_RE   = re_q;
endmodule

// File: tb/tb_rbcp_master.sv
// Scoreboard bench for rbcp_master: directed commands push expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_rbcp_master;
    localparam int K_WE = 0, K_RE = 1, K_RD = 2, K_DONE = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        err;
        logic [7:0]  cnt;
        int          refsel;   // 0 none, 1 delay from last strobe, 2 delay from accept
        int          dly;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rbcp_master_if bus ();

    rbcp_master #(.TIMEOUT_CYCLES(16), .ACT_LEAD(1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0, ack_cyc = 0, str_cyc = 0;
    bit   act_seen = 0, act_prev = 0;
    exp_t exp_q[$];
    int   ack_lat = 3;
    int   ack_budget = 0;
    logic [7:0] rd_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic push(input int kind, input logic [31:0] addr, input logic [7:0] data,
                        input logic err, input logic [7:0] cnt, input int refsel, input int dly);
        exp_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.err = err;
        e.cnt = cnt; e.refsel = refsel; e.dly = dly;
        exp_q.push_back(e);
    endtask

    task automatic next_exp(input int kind, input string name, output bit ok, output exp_t e);
        ok = 0;
        e = '{default: 0};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s actual=unexpected_event required=no_event", name);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL %s actual_kind=%0d required_kind=%0d", name, kind, e.kind);
            end else begin
                ok = 1;
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        if (bus.CMD_VALID && bus.CMD_READY) acc_cyc = cyc;
        if (bus.RBCP_ACK) ack_cyc = cyc;
        if (bus.RBCP_ACT) act_seen = 1'b1;
        if (bus.RBCP_WE || bus.RBCP_RE) chk("single_strobe", bus.RBCP_WE & bus.RBCP_RE, 1'b0);
        if (act_prev && !bus.RBCP_ACT && !rst) chk("act_drop_with_done", bus.DONE, 1'b1);
        act_prev = bus.RBCP_ACT;
        if (bus.RBCP_WE) begin
            str_cyc = cyc;
            next_exp(K_WE, "we_event", ok, e);
            if (ok) begin
                chk("we_addr", bus.RBCP_ADDR, e.addr);
                chk("we_data", bus.RBCP_WD, e.data);
            end
        end
        if (bus.RBCP_RE) begin
            str_cyc = cyc;
            next_exp(K_RE, "re_event", ok, e);
            if (ok) chk("re_addr", bus.RBCP_ADDR, e.addr);
        end
        if (bus.RD_VALID) begin
            next_exp(K_RD, "rd_event", ok, e);
            if (ok) begin
                chk("rd_data", bus.RD_DATA, e.data);
                chk("rd_latency", cyc - ack_cyc, 1);
            end
        end
        if (bus.DONE) begin
            next_exp(K_DONE, "done_event", ok, e);
            if (ok) begin
                chk("done_err", bus.ERR, e.err);
                chk("done_byte_cnt", bus.BYTE_CNT, e.cnt);
                chk("done_act_low", bus.RBCP_ACT, 1'b0);
                if (e.refsel == 1) chk("done_after_strobe", cyc - str_cyc, e.dly);
                if (e.refsel == 2) chk("done_after_accept", cyc - acc_cyc, e.dly);
            end
        end
    end

    // RBCP slave model: acknowledges each strobe ack_lat cycles later while budget lasts
    initial begin
        bit is_rd;
        forever begin
            @(negedge clk);
            if ((bus.RBCP_WE || bus.RBCP_RE) && !rst && ack_budget > 0) begin
                is_rd = bus.RBCP_RE;
                ack_budget--;
                repeat (ack_lat) @(posedge clk);
                #1;
                bus.RBCP_ACK = 1'b1;
                bus.RBCP_RD  = (is_rd && rd_bytes.size() > 0) ? rd_bytes.pop_front() : 8'h00;
                @(posedge clk);
                #1;
                bus.RBCP_ACK = 1'b0;
            end
        end
    end

    task automatic issue_cmd(input logic w, input logic [31:0] addr, input logic [7:0] len);
        bit got = 0;
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b1;
        bus.CMD_WRITE = w;
        bus.CMD_ADDR  = addr;
        bus.CMD_LEN   = len;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.CMD_READY) begin got = 1; break; end
        end
        if (!got) tmo("cmd_accept");
        @(posedge clk); #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int stall);
        bit got = 0;
        if (stall > 0) begin
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                if (bus.WD_READY) begin got = 1; break; end
            end
            if (!got) tmo("wd_ready_rise");
            repeat (stall) @(posedge clk);
            got = 0;
        end
        @(posedge clk); #1;
        bus.WD_VALID = 1'b1;
        bus.WD_DATA  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.WD_READY) begin got = 1; break; end
        end
        if (!got) tmo("wd_handshake");
        @(posedge clk); #1;
        bus.WD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit got = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin got = 1; break; end
        end
        if (!got) tmo(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_ctl"}, {bus.CMD_READY, bus.WD_READY, bus.RD_VALID, bus.DONE, bus.ERR,
                             bus.RBCP_ACT, bus.RBCP_WE, bus.RBCP_RE}, 8'h00);
        chk({name, "_addr"}, bus.RBCP_ADDR, 32'h0);
        chk({name, "_data"}, {bus.RD_DATA, bus.BYTE_CNT, bus.RBCP_WD}, 24'h0);
    endtask

    initial begin
        bus.CMD_VALID = 1'b0; bus.CMD_WRITE = 1'b0; bus.CMD_ADDR = '0; bus.CMD_LEN = '0;
        bus.WD_VALID = 1'b0;  bus.WD_DATA = '0;     bus.RBCP_RD = '0;  bus.RBCP_ACK = 1'b0;

        // Reset state and CMD_READY rising one cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_at_release", bus.CMD_READY, 1'b0);
        @(negedge clk);
        chk("ready_after_release", bus.CMD_READY, 1'b1);

        // Write burst of three bytes
        ack_lat = 3; ack_budget = 100;
        push(K_WE, 32'h10, 8'hA1, 0, 0, 0, 0);
        push(K_WE, 32'h11, 8'hB2, 0, 0, 0, 0);
        push(K_WE, 32'h12, 8'hC3, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1'b0, 8'd3, 0, 0);
        issue_cmd(1'b1, 32'h10, 8'd3);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        wait_idle("write3_done");

        // Read burst of two bytes
        rd_bytes.push_back(8'h5A); rd_bytes.push_back(8'h3C);
        push(K_RE, 32'h0001_0000, 0, 0, 0, 0, 0);
        push(K_RD, 0, 8'h5A, 0, 0, 0, 0);
        push(K_RE, 32'h0001_0001, 0, 0, 0, 0, 0);
        push(K_RD, 0, 8'h3C, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1'b0, 8'd2, 0, 0);
        issue_cmd(1'b0, 32'h0001_0000, 8'd2);
        wait_idle("read2_done");

        // Read with third byte never acknowledged
        ack_budget = 2;
        rd_bytes.push_back(8'h11); rd_bytes.push_back(8'h22);
        push(K_RE, 32'h200, 0, 0, 0, 0, 0);
        push(K_RD, 0, 8'h11, 0, 0, 0, 0);
        push(K_RE, 32'h201, 0, 0, 0, 0, 0);
        push(K_RD, 0, 8'h22, 0, 0, 0, 0);
        push(K_RE, 32'h202, 0, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1'b1, 8'd2, 1, 16);
        issue_cmd(1'b0, 32'h200, 8'd4);
        wait_idle("timeout_done");
        repeat (3) @(negedge clk);
        chk("err_held", bus.ERR, 1'b1);
        chk("act_low_after_timeout", bus.RBCP_ACT, 1'b0);

        // Next command after a timeout is accepted and clears ERR
        ack_budget = 100;
        rd_bytes.push_back(8'h77);
        push(K_RE, 32'h400, 0, 0, 0, 0, 0);
        push(K_RD, 0, 8'h77, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1'b0, 8'd1, 0, 0);
        issue_cmd(1'b0, 32'h400, 8'd1);
        wait_idle("after_timeout_done");

        // Address wrap with a long write-data stall
        push(K_WE, 32'hFFFF_FFFF, 8'h5E, 0, 0, 0, 0);
        push(K_WE, 32'h0000_0000, 8'hE7, 0, 0, 0, 0);
        push(K_DONE, 0, 0, 1'b0, 8'd2, 0, 0);
        issue_cmd(1'b1, 32'hFFFF_FFFF, 8'd2);
        send_byte(8'h5E, 0);
        send_byte(8'hE7, 20);
        wait_idle("wrap_done");

        // Spurious ACK while idle
        @(posedge clk); #1;
        bus.RBCP_ACK = 1'b1; bus.RBCP_RD = 8'hEE;
        @(posedge clk); #1;
        bus.RBCP_ACK = 1'b0;
        repeat (3) @(negedge clk);
        chk("spurious_byte_cnt", bus.BYTE_CNT, 8'd2);
        chk("spurious_ready", bus.CMD_READY, 1'b1);

        // Zero-length command
        act_seen = 0;
        push(K_DONE, 0, 0, 1'b0, 8'd0, 2, 1);
        issue_cmd(1'b0, 32'h1234, 8'd0);
        wait_idle("len0_done");
        chk("len0_act_never", act_seen, 1'b0);
        chk("len0_byte_cnt", bus.BYTE_CNT, 8'd0);

        // Reset while waiting for ACK
        ack_budget = 0;
        push(K_RE, 32'h300, 0, 0, 0, 0, 0);
        issue_cmd(1'b0, 32'h300, 8'd5);
        wait_idle("rst_read_strobe");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midcmd_reset");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midcmd_ready_at_release", bus.CMD_READY, 1'b0);
        @(negedge clk);
        chk("midcmd_ready_after_release", bus.CMD_READY, 1'b1);
        repeat (24) @(negedge clk);
        chk("no_pending_events", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule
